// File: rtl/param_stack_unit.sv
// param_stack_unit: parametrised data/return stack. The top two entries live in
// sr0/sr1; deeper entries live in mem[], where mem[depth-3] is the third entry.
// Optional feature macro: STACK_PEEK_EN adds the peek_idx/peek_data read port.
module param_stack_unit #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] sr0,
    output logic [WIDTH-1:0] sr1,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             err_ovf,
    output logic             err_unf,
    output logic             err_ill
`ifdef STACK_PEEK_EN
    ,
    input  logic [$clog2(DEPTH)-1:0] peek_idx,
    output logic [WIDTH-1:0]         peek_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int MW = DEPTH - 2;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_PUSH  = 4'd1,
        OP_POP   = 4'd2,
        OP_DUP   = 4'd3,
        OP_SWAP  = 4'd4,
        OP_OVER  = 4'd5,
        OP_ROT   = 4'd6,
        OP_REPL  = 4'd7,
        OP_BINOP = 4'd8,
        OP_CLEAR = 4'd9
    } op_t;

    logic [WIDTH-1:0] mem [MW];

    op_t              op_dec;
    logic [DW-1:0]    need_min;
    logic             need_room;
    logic             ill, unf, ovf, ok;
    logic [AW-1:0]    idx2, spill_idx;
    logic [WIDTH-1:0] below;
    logic [WIDTH-1:0] sr0_n, sr1_n;
    logic [DW-1:0]    depth_n;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    assign op_dec    = op_t'(op);
    assign empty     = (depth == '0);
    assign full      = (depth == DW'(DEPTH));
    assign idx2      = AW'(depth - DW'(3));
    assign spill_idx = AW'(depth - DW'(2));

    // Decode the op's requirements; underflow takes precedence over overflow.
    always_comb begin
        need_min  = '0;
        need_room = 1'b0;
        ill       = 1'b0;
        case (op_dec)
            OP_PUSH:           need_room = 1'b1;
            OP_POP, OP_REPL:   need_min  = DW'(1);
            OP_DUP: begin
                need_min  = DW'(1);
                need_room = 1'b1;
            end
            OP_SWAP, OP_BINOP: need_min  = DW'(2);
            OP_OVER: begin
                need_min  = DW'(2);
                need_room = 1'b1;
            end
            OP_ROT:            need_min  = DW'(3);
            OP_NOP, OP_CLEAR:  ;
            default:           ill       = 1'b1;
        endcase
        unf = !ill && (depth < need_min);
        ovf = !ill && !unf && need_room && full;
        ok  = !ill && !unf && !ovf;
    end

    // Next-state for the register pair, depth and the single array write port.
    // PUSH/DUP/OVER share one push path: only the value entering sr0 differs.
    always_comb begin
        below   = (depth >= DW'(3)) ? mem[idx2] : '0;
        sr0_n   = sr0;
        sr1_n   = sr1;
        depth_n = depth;
        mem_we  = 1'b0;
        mem_wa  = idx2;
        mem_wd  = '0;
        if (ok) begin
            case (op_dec)
                OP_PUSH, OP_DUP, OP_OVER: begin
                    sr0_n   = (op_dec == OP_PUSH) ? push_data :
                              (op_dec == OP_DUP)  ? sr0 : sr1;
                    sr1_n   = sr0;
                    depth_n = depth + DW'(1);
                    mem_we  = (depth >= DW'(2));
                    mem_wa  = spill_idx;
                    mem_wd  = sr1;
                end
                OP_POP, OP_BINOP: begin
                    sr0_n   = (op_dec == OP_POP) ? sr1 : push_data;
                    sr1_n   = below;
                    depth_n = depth - DW'(1);
                    mem_we  = (depth >= DW'(3));
                end
                OP_SWAP: begin
                    sr0_n = sr1;
                    sr1_n = sr0;
                end
                OP_ROT: begin
                    sr0_n  = below;
                    sr1_n  = sr0;
                    mem_we = 1'b1;
                    mem_wd = sr1;
                end
                OP_REPL:  sr0_n = push_data;
                OP_CLEAR: begin
                    sr0_n   = '0;
                    sr1_n   = '0;
                    depth_n = '0;
                end
                default: ;
            endcase
        end
    end

    // Register the top entries, depth and the one-cycle error pulses.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            sr0     <= '0;
            sr1     <= '0;
            depth   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            err_ill <= 1'b0;
        end else begin
            sr0     <= sr0_n;
            sr1     <= sr1_n;
            depth   <= depth_n;
            err_ovf <= ovf;
            err_unf <= unf;
            err_ill <= ill;
        end
    end

    // Array storage beyond sr1; not reset since depth gates every read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

`ifdef STACK_PEEK_EN
    // Combinational peek: index 0/1 from registers, deeper indices from the array.
    always_comb begin
        peek_data = '0;
        if (DW'(peek_idx) < depth) begin
            if (peek_idx == '0) begin
                peek_data = sr0;
            end else if (peek_idx == AW'(1)) begin
                peek_data = sr1;
            end else begin
                peek_data = mem[AW'(depth - DW'(1) - DW'(peek_idx))];
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_stack_unit.sv
// tb_param_stack_unit: directed and randomized checks of param_stack_unit against
// a queue-based stack model (element 0 of the queue is the top of stack).
module tb_param_stack_unit;

    localparam int W = 16;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         async_reset;
    logic [3:0]   op;
    logic [W-1:0] push_data;
    logic [W-1:0] sr0, sr1;
    logic [4:0]   depth;
    logic         empty, full, err_ovf, err_unf, err_ill;
`ifdef STACK_PEEK_EN
    logic [3:0]   peek_idx;
    logic [W-1:0] peek_data;
`endif

    param_stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .async_reset(async_reset),
        .op         (op),
        .push_data  (push_data),
        .sr0        (sr0),
        .sr1        (sr1),
        .depth      (depth),
        .empty      (empty),
        .full       (full),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf),
        .err_ill    (err_ill)
`ifdef STACK_PEEK_EN
        ,
        .peek_idx   (peek_idx),
        .peek_data  (peek_data)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] model [$];
    logic exp_ovf, exp_unf, exp_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference stack semantics expressed directly on the queue.
    task automatic model_op(input logic [3:0] o, input logic [W-1:0] d);
        int n;
        logic [W-1:0] a, b, c;
        n = model.size();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        exp_ill = 1'b0;
        case (o)
            4'd0: ;
            4'd1: if (n == D) exp_ovf = 1'b1; else model.push_front(d);
            4'd2: if (n < 1) exp_unf = 1'b1; else model.delete(0);
            4'd3: if (n < 1) exp_unf = 1'b1; else if (n == D) exp_ovf = 1'b1;
                  else model.push_front(model[0]);
            4'd4: if (n < 2) exp_unf = 1'b1;
                  else begin a = model[0]; model[0] = model[1]; model[1] = a; end
            4'd5: if (n < 2) exp_unf = 1'b1; else if (n == D) exp_ovf = 1'b1;
                  else model.push_front(model[1]);
            4'd6: if (n < 3) exp_unf = 1'b1;
                  else begin
                      a = model[0]; b = model[1]; c = model[2];
                      model[0] = c; model[1] = a; model[2] = b;
                  end
            4'd7: if (n < 1) exp_unf = 1'b1; else model[0] = d;
            4'd8: if (n < 2) exp_unf = 1'b1;
                  else begin model.delete(0); model.delete(0); model.push_front(d); end
            4'd9: model.delete();
            default: exp_ill = 1'b1;
        endcase
    endtask

    task automatic check_state(input string tag);
        int n;
        n = model.size();
        check({tag, ".sr0"},   sr0,     (n > 0) ? 32'(model[0]) : 32'd0);
        check({tag, ".sr1"},   sr1,     (n > 1) ? 32'(model[1]) : 32'd0);
        check({tag, ".depth"}, depth,   n);
        check({tag, ".empty"}, empty,   n == 0);
        check({tag, ".full"},  full,    n == D);
        check({tag, ".ovf"},   err_ovf, exp_ovf);
        check({tag, ".unf"},   err_unf, exp_unf);
        check({tag, ".ill"},   err_ill, exp_ill);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] d);
        @(negedge clk);
        op        = o;
        push_data = d;
        @(posedge clk);
        model_op(o, d);
        #1;
        check_state($sformatf("op%0d", o));
        op = 4'd0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".sr0"},   sr0,     0);
        check({tag, ".sr1"},   sr1,     0);
        check({tag, ".depth"}, depth,   0);
        check({tag, ".empty"}, empty,   1);
        check({tag, ".full"},  full,    0);
        check({tag, ".errs"},  {err_ovf, err_unf, err_ill}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        async_reset = 1'b1;
        op          = 4'd0;
        push_data   = '0;
`ifdef STACK_PEEK_EN
        peek_idx    = '0;
`endif
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        exp_ill = 1'b0;
        #12;
        reset_checks("reset");
        @(negedge clk);
        async_reset = 1'b0;

        // Two pushes straight after reset.
        run_op(4'd1, 16'h0004);
        run_op(4'd1, 16'h0005);
        check("push2.sr0", sr0, 16'h0005);
        check("push2.sr1", sr1, 16'h0004);
        check("push2.depth", depth, 2);

        // Fill to full, overflow, drain, underflow.
        run_op(4'd9, '0);
        for (int i = 1; i <= D; i++) run_op(4'd1, W'(i));
        check("fill.full", full, 1);
        run_op(4'd1, 16'hBEEF);
        check("ovf.pulse", err_ovf, 1);
        check("ovf.sr0", sr0, 16);
        check("ovf.depth", depth, 16);
        run_op(4'd0, '0);
        check("ovf.clear", err_ovf, 0);
        for (int i = 0; i < D; i++) run_op(4'd2, '0);
        check("drain.empty", empty, 1);
        run_op(4'd2, '0);
        check("unf.pulse", err_unf, 1);
        run_op(4'd0, '0);

        // ROT / SWAP / OVER on 1,2,3.
        run_op(4'd1, 16'd1);
        run_op(4'd1, 16'd2);
        run_op(4'd1, 16'd3);
`ifdef STACK_PEEK_EN
        peek_idx = 4'd2;
        #1 check("peek2", peek_data, 1);
        peek_idx = 4'd5;
        #1 check("peek5", peek_data, 0);
`endif
        run_op(4'd6, '0);
        check("rot.sr0", sr0, 1);
        check("rot.sr1", sr1, 3);
        run_op(4'd4, '0);
        check("swap.sr0", sr0, 3);
        check("swap.sr1", sr1, 1);
        run_op(4'd5, '0);
        check("over.sr0", sr0, 1);
        check("over.depth", depth, 4);

        // BINOP on 7,8,9.
        run_op(4'd9, '0);
        run_op(4'd1, 16'd7);
        run_op(4'd1, 16'd8);
        run_op(4'd1, 16'd9);
        run_op(4'd8, 16'h0011);
        check("binop.sr0", sr0, 16'h0011);
        check("binop.sr1", sr1, 7);
        check("binop.depth", depth, 2);

        // Illegal op at depth 2, then async reset between edges.
        run_op(4'hC, '0);
        check("ill.pulse", err_ill, 1);
        #2;
        async_reset = 1'b1;
        #1;
        reset_checks("midreset");
        @(negedge clk);
        async_reset = 1'b0;
        model.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        exp_ill = 1'b0;
        run_op(4'd1, 16'h1234);

        // Randomized ops, biased toward PUSH/POP so depth sweeps the whole range.
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            logic [3:0] o;
            r = $urandom_range(0, 99);
            if (r < 40)      o = 4'd1;
            else if (r < 62) o = 4'd2;
            else             o = 4'($urandom_range(0, 15));
            run_op(o, W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
